// File: rtl/pkg_isa.sv
// rtl/pkg_isa.sv - shared ISA constants, fetch state encoding and field helpers
package pkg_isa;

  localparam logic [3:0] OP_RTYPE = 4'b1111;
  localparam logic [3:0] OP_ANDI  = 4'b1000;
  localparam logic [3:0] OP_ORI   = 4'b1001;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JUMP  = 4'b0001;
  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_NOP   = 4'b0011;

  // R-type function codes carried in the low nibble
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_SLT = 4'b0100;
  localparam logic [3:0] FN_SLL = 4'b0101;
  localparam logic [3:0] FN_SRL = 4'b0110;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    FS_RUN       = 2'd0,
    FS_HALT_PEND = 2'd1,
    FS_HALTED    = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] funct_of(input logic [15:0] instr);
    return instr[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/st1_fetch_unit_if.sv
// rtl/st1_fetch_unit_if.sv - instruction-memory, redirect and IF/ID bus of the fetch unit
interface st1_fetch_unit_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [15:0]     if_id_instr;
  logic [PC_W-1:0] if_id_pc2;
  logic            if_id_valid;
  logic            halted;
  logic [15:0]     perf_fetched;
  logic [15:0]     perf_stalls;

  modport master (
    output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted,
           perf_fetched, perf_stalls,
    input  imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted,
           perf_fetched, perf_stalls,
    output imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/st1_fetch_unit_if_id.sv
// rtl/st1_fetch_unit_if_id.sv - IF/ID pipeline register with hold and flush-to-bubble
module st1_if_id_reg #(
  parameter int              PC_W         = 16,
  parameter logic [15:0]     BUBBLE_INSTR = 16'h3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [15:0]     fetch_instr,
  input  logic [PC_W-1:0] fetch_pc2,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc2,
  output logic            valid
);

  // flush beats hold so a redirect during a stall still kills the wrong path
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= BUBBLE_INSTR;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= fetch_instr;
      pc2   <= fetch_pc2;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/st1_fetch_unit.sv
// rtl/st1_fetch_unit.sv - stage-1 fetch: PC, halt sequencing, IF/ID; FETCH_PERF_CNT_EN adds perf counters
module st1_fetch_unit
  import pkg_isa::*;
#(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter logic [15:0]     BUBBLE_INSTR = 16'h3000,
  parameter int              HALT_SHADOW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  st1_fetch_unit_if.master bus
);

  fetch_state_t    state, state_n;
  logic [2:0]      shadow, shadow_n;
  logic [PC_W-1:0] pc, pc_n, pc_plus2;
  logic            ifid_hold, ifid_flush;
  logic            halted_q;
  logic [15:0]     ifid_instr;
  logic [PC_W-1:0] ifid_pc2;
  logic            ifid_valid;
  logic            is_halt;

  assign pc_plus2      = pc + PC_W'(2);
  assign is_halt       = (opcode_of(bus.imem_data) == OP_HALT);
  assign bus.imem_addr = pc;

  // Priority: redirect > frozen > stall > shadow countdown > normal fetch
  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    pc_n       = pc;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    if (bus.redirect && state != FS_HALTED) begin
      pc_n       = bus.redirect_pc & ~PC_W'(1);
      ifid_flush = 1'b1;
      state_n    = FS_RUN;
      shadow_n   = 3'd0;
    end else if (state == FS_HALTED) begin
      ifid_flush = 1'b1;
    end else if (bus.stall) begin
      ifid_hold  = 1'b1;
    end else if (state == FS_HALT_PEND) begin
      ifid_flush = 1'b1;
      shadow_n   = shadow - 3'd1;
      if (shadow == 3'd1) begin
        state_n = FS_HALTED;
      end
    end else if (is_halt) begin
      // halt enters IF/ID but PC stays on it until the shadow expires
      state_n  = FS_HALT_PEND;
      shadow_n = 3'(HALT_SHADOW);
    end else begin
      pc_n = pc_plus2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_RUN;
      shadow   <= 3'd0;
      pc       <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      pc       <= pc_n;
      halted_q <= (state_n == FS_HALTED);
    end
  end

  st1_if_id_reg #(
    .PC_W         (PC_W),
    .BUBBLE_INSTR (BUBBLE_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .hold        (ifid_hold),
    .flush       (ifid_flush),
    .fetch_instr (bus.imem_data),
    .fetch_pc2   (pc_plus2),
    .instr       (ifid_instr),
    .pc2         (ifid_pc2),
    .valid       (ifid_valid)
  );

  assign bus.if_id_instr = ifid_instr;
  assign bus.if_id_pc2   = ifid_pc2;
  assign bus.if_id_valid = ifid_valid;
  assign bus.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_q, stalls_q;
  logic        fetch_load;

  assign fetch_load = !ifid_hold && !ifid_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 16'h0000;
      stalls_q  <= 16'h0000;
    end else begin
      if (fetch_load && fetched_q != 16'hFFFF) begin
        fetched_q <= fetched_q + 16'd1;
      end
      if (ifid_hold && stalls_q != 16'hFFFF) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  assign bus.perf_fetched = fetched_q;
  assign bus.perf_stalls  = stalls_q;
`else
  assign bus.perf_fetched = 16'h0000;
  assign bus.perf_stalls  = 16'h0000;
`endif

endmodule

// File: doc/st1_fetch_unit.md
Name: st1_fetch_unit

Overview:
- Stage-1 instruction fetch for the 16-bit pipelined datapath. It is the producer of the 16-bit instruction whose OpCode [15:12] and Funct [3:0] fields feed the stage-2 control unit.
- Owns the PC, the instruction-memory read address and the IF/ID pipeline register.
- Applies stall, branch/jump redirect and flush, and halt sequencing on opcode 0000.

Parameters:
- PC_W, 16, PC width; byte address; wraps modulo 2^PC_W.
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUBBLE_INSTR, 16'h3000, instruction driven when IF/ID holds a bubble; unused opcode 0011 is decoded as a no-op.
- HALT_SHADOW, 2, cycles a fetched halt stays cancellable before the unit freezes; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_addr  out  PC_W  instruction-memory address; equals current PC.
- imem_data  in  16  instruction at imem_addr; combinational, same cycle.
- stall  in  1  hazard-unit hold request.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_pc  in  PC_W  redirect target; bit 0 is ignored and forced to 0.
- if_id_instr  out  16  registered instruction to stage 2.
- if_id_pc2  out  PC_W  registered PC+2 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  fetch frozen by a committed halt.
- perf_fetched  out  16  fetched-instruction count; see Optional Feature.
- perf_stalls  out  16  stall-cycle count; see Optional Feature.

Behaviour:
- Reset values (rst=1 at an edge): PC=RESET_PC, if_id_instr=BUBBLE_INSTR, if_id_pc2=0, if_id_valid=0, halted=0, state=RUN, shadow counter=0, perf counters=0. Reset overrides every other input, including mid-halt and mid-stall.
- Latency: the instruction at PC appears on if_id_* one edge after PC is presented.
- Event priority per edge: rst > redirect > state HALTED > stall > normal fetch.
- States:
  - RUN: fetch normally.
  - HALT_PEND: a halt has been fetched; the shadow counter runs.
  - HALTED: fetch frozen.
- RUN, normal fetch (stall=0, redirect=0):
  - if_id_instr=imem_data, if_id_pc2=PC+2, if_id_valid=1.
  - PC=PC+2, truncated to PC_W. 0xFFFE+2 wraps to 0x0000.
  - If imem_data[15:12]==0000, latch the halt into IF/ID, do not advance PC, load shadow counter=HALT_SHADOW, go to HALT_PEND.
- stall=1 (no redirect): PC and all if_id_* hold. Perf stall count increments. State and shadow counter also hold.
- redirect=1, in RUN or HALT_PEND, regardless of stall:
  - PC={redirect_pc[PC_W-1:1],1'b0}.
  - IF/ID flushes to bubble: instr=BUBBLE_INSTR, valid=0.
  - State goes to RUN. This cancels a pending halt; it is the wrong-path flush.
- HALT_PEND, no redirect:
  - IF/ID loads a bubble each cycle after the halt leaves (if stall=0).
  - Shadow counter decrements when stall=0. At the transition to 0, go to HALTED and set halted=1.
- HALTED:
  - PC frozen; IF/ID holds a bubble; halted=1.
  - redirect and stall are ignored; only rst exits.
- Flags: halted is registered. The imem_addr output is combinational from PC.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every edge that loads if_id_valid=1.
  - perf_stalls increments on every stall edge while not HALTED.
  - Both are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: both ports are tied to 16'h0000 and no counter flops exist. Ports stay present so instantiations do not change.

Decomposition:
- Shared package/header pkg_isa:
  - Opcode constants: OP_RTYPE=1111, OP_ANDI=1000, OP_ORI=1001, OP_LBU=1010, OP_SB=1011, OP_LW=1100, OP_SW=1101, OP_BGT=0100, OP_BLT=0101, OP_BEQ=0110, OP_JUMP=0001, OP_HALT=0000, OP_NOP=0011.
  - Funct constants.
  - Fetch state encoding: RUN=2'd0, HALT_PEND=2'd1, HALTED=2'd2.
  - Field slice positions [15:12] and [3:0].
- Sub-module: st1_if_id_reg, the IF/ID register with hold (stall) and flush-to-bubble controls. The PC/FSM logic stays in st1_fetch_unit.

Test Plan:
- Reset, then imem returns F000 (add) at 0x0000 and F001 at 0x0002 → cycle 1: if_id_instr=F000, pc2=0x0002, valid=1; cycle 2: F001, pc2=0x0004; imem_addr steps 0,2,4.
- stall held 3 cycles after fetching 8xxx (andi) at 0x0004 → imem_addr stays 0x0006; if_id_instr stays 8xxx for 3 cycles; perf_stalls=3 with the macro defined, 0 without.
- redirect=1 with redirect_pc=0x0041 and stall=1 in the same cycle → next PC=0x0040; if_id_instr=3000, valid=0.
- Opcode 0000 fetched at 0x0010, HALT_SHADOW=2, no redirect → HALT_PEND; halted=1 two edges later; PC frozen at 0x0010; a later redirect is ignored.
- Halt fetched, then redirect to 0x0020 one cycle later → state returns to RUN, halted never asserts, fetch resumes at 0x0020. In a separate case, rst asserted while HALTED → all reset values restored next edge.
- PC=0xFFFE with normal fetch → if_id_pc2=0x0000 and imem_addr wraps to 0x0000.
